// File: rtl/oam_dma_pkg.sv
// rtl/oam_dma_pkg.sv - shared state encoding and bus addresses for the sprite DMA engine
// Purpose: types and constants imported by oam_dma.
//   dma_state_t     : engine state (3-bit)
//   ADDR_OAMDMA     : CPU register address that starts a transfer ($4014)
//   ADDR_OAMDATA    : PPU OAMDATA port written by the engine ($2004)
//   XFER_BYTES_NES  : bytes moved per transfer
package oam_dma_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_READ  = 3'd3,
    DMA_WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] ADDR_OAMDMA    = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA   = 16'h2004;
  localparam int          XFER_BYTES_NES = 256;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - NES sprite DMA engine sitting between the CPU core and the system bus
// Purpose: a CPU write to DMA_REG_ADDR stalls the core and copies XFER_BYTES bytes from
// page {val,8'h00} to OAM_PORT_ADDR. When idle the CPU bus is passed through untouched.
// Ports:
//   i_clk          system clock, one CPU cycle per rising edge
//   i_reset        asynchronous active-high reset
//   i_cpu_addr     CPU address output
//   i_cpu_wdata    CPU write data
//   i_cpu_rw       CPU direction, 1=read 0=write
//   i_bus_rdata    read data returned by the system bus
//   o_bus_addr     address driven to the system bus
//   o_bus_wdata    write data driven to the system bus
//   o_bus_rw       bus direction, 1=read 0=write
//   o_cpu_stall    CPU core must not advance this cycle
//   o_dma_active   engine owns the bus
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
  parameter logic [15:0] OAM_PORT_ADDR = ADDR_OAMDATA,
  parameter int          XFER_BYTES    = XFER_BYTES_NES
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  input  logic        i_cpu_rw,
  input  logic [7:0]  i_bus_rdata,
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_wdata,
  output logic        o_bus_rw,
  output logic        o_cpu_stall,
  output logic        o_dma_active
);

  localparam logic [8:0] LAST_IDX = 9'(XFER_BYTES - 1);

  dma_state_t  r_state;
  logic        r_parity;
  logic [7:0]  r_page;
  logic [7:0]  r_latch;
  logic [8:0]  r_idx;

  logic        w_trigger;

  // Reads of the DMA register never start a transfer; only a CPU write does.
  assign w_trigger = !i_cpu_rw && (i_cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= DMA_IDLE;
      r_parity <= 1'b0;
      r_page   <= 8'h00;
      r_idx    <= 9'd0;
      r_latch  <= 8'h00;
    end else begin
      // Free-running cycle parity; 1 marks an odd CPU cycle.
      r_parity <= ~r_parity;
      case (r_state)
        DMA_IDLE: begin
          if (w_trigger) begin
            r_page  <= i_cpu_wdata;
            r_idx   <= 9'd0;
            r_state <= DMA_HALT;
          end
        end
        // An extra dummy cycle keeps the read/write pairs on the proper cycle parity.
        DMA_HALT:  r_state <= r_parity ? DMA_ALIGN : DMA_READ;
        DMA_ALIGN: r_state <= DMA_READ;
        DMA_READ: begin
          r_latch <= i_bus_rdata;
          r_state <= DMA_WRITE;
        end
        DMA_WRITE: begin
          r_idx   <= r_idx + 9'd1;
          r_state <= (r_idx == LAST_IDX) ? DMA_IDLE : DMA_READ;
        end
        default: r_state <= DMA_IDLE;
      endcase
    end
  end

  always_comb begin
    o_bus_addr  = i_cpu_addr;
    o_bus_wdata = i_cpu_wdata;
    o_bus_rw    = i_cpu_rw;
    case (r_state)
      // Dummy cycles present the CPU address as a read so the bus sees no side effect.
      DMA_HALT, DMA_ALIGN: begin
        o_bus_rw = 1'b1;
      end
      DMA_READ: begin
        // Low byte comes only from idx[7:0]; nothing carries into the page.
        o_bus_addr  = {r_page, r_idx[7:0]};
        o_bus_wdata = r_latch;
        o_bus_rw    = 1'b1;
      end
      DMA_WRITE: begin
        o_bus_addr  = OAM_PORT_ADDR;
        o_bus_wdata = r_latch;
        o_bus_rw    = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_dma_active = (r_state != DMA_IDLE);
  assign o_cpu_stall  = o_dma_active;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - self-checking bench for oam_dma
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic [7:0]  bus_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rw;
  logic        cpu_stall;
  logic        dma_active;

  logic [7:0]  mem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit          m_active = 1'b0;
  int          m_t      = 0;
  int          m_edges  = 0;
  bit          m_align  = 1'b0;
  logic [7:0]  m_page   = 8'h00;

  // observation logs
  logic [7:0]  oam_q[$];
  int          stall_cnt   = 0;
  int          zero_cnt    = 0;
  logic [15:0] last_rd     = 16'h0000;
  int          first_rd_t  = -1;

  oam_dma dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .i_cpu_rw     (cpu_rw),
    .i_bus_rdata  (bus_rdata),
    .o_bus_addr   (bus_addr),
    .o_bus_wdata  (bus_wdata),
    .o_bus_rw     (bus_rw),
    .o_cpu_stall  (cpu_stall),
    .o_dma_active (dma_active)
  );

  always #5 clk = ~clk;

  assign bus_rdata = mem[bus_addr];

  // Model: a transfer is a timeline of 1 halt cycle, an optional align cycle
  // (when the halt cycle lands on odd parity), then 256 read/write pairs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_edges  <= 0;
    end else begin
      m_edges <= m_edges + 1;
      if (m_active) begin
        m_t      <= m_t + 1;
        m_active <= (m_t + 1) < (513 + int'(m_align));
      end else if (!cpu_rw && cpu_addr == 16'h4014) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_page   <= cpu_wdata;
        m_align  <= ((m_edges + 1) % 2) == 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus logging.
  always @(negedge clk) begin
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        er, es, chk_d;
    int          u, i;
    ea = cpu_addr; ed = cpu_wdata; er = cpu_rw; es = 1'b0; chk_d = 1'b1;
    if (m_active) begin
      es = 1'b1;
      if (m_t == 0 || (m_align && m_t == 1)) begin
        er = 1'b1; chk_d = 1'b0;
      end else begin
        u = m_t - 1 - int'(m_align);
        i = u / 2;
        if (u % 2 == 0) begin
          ea = {m_page, 8'(i)}; er = 1'b1; chk_d = 1'b0;
        end else begin
          ea = 16'h2004; ed = mem[{m_page, 8'(i)}]; er = 1'b0;
        end
      end
    end
    n_tests++;
    if (bus_addr !== ea || bus_rw !== er || cpu_stall !== es || dma_active !== es ||
        (chk_d && bus_wdata !== ed)) begin
      n_fail++;
      $display("FAIL cycle t=%0d: got addr=%h rw=%b wd=%h stall=%b act=%b, want addr=%h rw=%b wd=%h stall=%b",
               m_t, bus_addr, bus_rw, bus_wdata, cpu_stall, dma_active, ea, er, ed, es);
    end
    if (cpu_stall) begin
      stall_cnt++;
      if (!bus_rw && bus_addr == 16'h2004) oam_q.push_back(bus_wdata);
      if (bus_rw) begin
        last_rd = bus_addr;
        if (bus_addr == 16'h0000) zero_cnt++;
        if (m_active && m_t < 4 && bus_addr == {m_page, 8'h00}) first_rd_t = m_t;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp_v);
    end
  endtask

  task automatic idle_cpu();
    cpu_addr = 16'h8000; cpu_wdata = 8'h00; cpu_rw = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic trigger(input logic [7:0] page, input bit want_align);
    for (int k = 0; k < 4; k++) begin
      if (((m_edges + 1) % 2) == int'(want_align)) break;
      step(1);
    end
    cpu_addr = 16'h4014; cpu_wdata = page; cpu_rw = 1'b0;
    step(1);
    idle_cpu();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((m_active || cpu_stall) && k < 2000) begin
      step(1);
      k++;
    end
    if (k >= 2000) begin
      n_tests++; n_fail++;
      $display("FAIL wait_done: transfer did not finish within 2000 cycles");
    end
  endtask

  task automatic run_xfer(input string name, input logic [7:0] page, input bit align, input bit poke);
    int s0, q0, z0, bad;
    s0 = stall_cnt; q0 = oam_q.size(); z0 = zero_cnt;
    trigger(page, align);
    if (poke) begin
      step(50);
      cpu_addr = 16'h4014; cpu_wdata = page ^ 8'h01; cpu_rw = 1'b0;
      step(3);
      idle_cpu();
    end
    wait_done();
    check({name, " stall_len"}, stall_cnt - s0, align ? 514 : 513);
    check({name, " n_writes"}, oam_q.size() - q0, 256);
    check({name, " first_read_t"}, first_rd_t, align ? 2 : 1);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (q0 + i >= oam_q.size() || oam_q[q0 + i] !== mem[{page, 8'(i)}]) bad++;
    check({name, " data_bad"}, bad, 0);
    check({name, " last_read"}, last_rd, {page, 8'hFF});
    if (page != 8'h00) check({name, " zero_access"}, zero_cnt - z0, 0);
  endtask

  initial begin
    int q0, k;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'(i);

    rst = 1'b1;
    idle_cpu();
    step(3);
    check("reset stall", cpu_stall, 0);
    check("reset active", dma_active, 0);
    check("reset passthru", bus_addr, 16'h8000);
    rst = 1'b0;
    step(2);

    // 1: even trigger, 513 cycles
    run_xfer("t1", 8'h02, 1'b0, 1'b0);
    // 2: odd trigger, 514 cycles
    run_xfer("t2", 8'h02, 1'b1, 1'b0);
    // 3: page FF, hand values pin the model
    run_xfer("t3", 8'hFF, 1'b0, 1'b0);
    check("t3 last data", oam_q[oam_q.size() - 1], 8'hFF);
    check("t3 data80", oam_q[oam_q.size() - 128], 8'h80);

    // 4: reset at write #100
    q0 = oam_q.size();
    trigger(8'h03, 1'b0);
    k = 0;
    while (oam_q.size() - q0 < 100 && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    check("t4 reached 100", oam_q.size() - q0, 100);
    rst = 1'b1;
    #1;
    check("t4 stall async", cpu_stall, 0);
    check("t4 active async", dma_active, 0);
    step(1);
    cpu_addr = 16'h4014; cpu_wdata = 8'h05; cpu_rw = 1'b0;
    step(1);
    idle_cpu();
    rst = 1'b0;
    step(20);
    check("t4 no retrigger", cpu_stall, 0);
    check("t4 writes frozen", oam_q.size() - q0, 100);
    run_xfer("t4b", 8'h04, 1'b1, 1'b0);

    // 5: read $4014 / write $4015 pass straight through
    cpu_addr = 16'h4014; cpu_wdata = 8'hAB; cpu_rw = 1'b1;
    #1;
    check("t5 rd addr", bus_addr, 16'h4014);
    check("t5 rd rw", bus_rw, 1);
    step(1);
    check("t5 rd stall", cpu_stall, 0);
    cpu_addr = 16'h4015; cpu_wdata = 8'h5A; cpu_rw = 1'b0;
    #1;
    check("t5 wr addr", bus_addr, 16'h4015);
    check("t5 wr data", bus_wdata, 8'h5A);
    check("t5 wr rw", bus_rw, 0);
    step(1);
    check("t5 wr stall", cpu_stall, 0);
    idle_cpu();
    step(2);

    // 6: write to $4014 during an active transfer is ignored
    run_xfer("t6", 8'h06, 1'b0, 1'b1);

    // random phase: noisy CPU bus with occasional triggers, checked cycle by cycle
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 60) == 0) begin
        cpu_addr = 16'h4014; cpu_rw = 1'b0;
      end else begin
        cpu_addr = 16'($urandom); cpu_rw = 1'($urandom);
      end
      cpu_wdata = 8'($urandom);
      step(1);
    end
    idle_cpu();
    wait_done();
    check("final idle", cpu_stall, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
